// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and the
// default operand width.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder; purely combinational, reused by the serial adder
// for the per-bit add.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);

  // Sum and carry of three one-bit inputs.
  always_comb begin
    sum   = a ^ b ^ c;
    carry = (a & b) | (a & c) | (b & c);
  end

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle bit-serial adder. Operands are captured on an accepted start
// and added LSB first, one bit per clock, through a single full adder.
// The result registers only change when the last bit has been processed,
// so a previous result stays visible while a new add is running.
// Optional feature: define SERIAL_ADDER_OVF_EN to add overflow_out, the
// signed two's-complement overflow of the completed add.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             c_in,
  output logic             busy_out,
  output logic             done_out,
  output logic [WIDTH-1:0] sum_out,
`ifdef SERIAL_ADDER_OVF_EN
  output logic             carry_out,
  output logic             overflow_out
`else
  output logic             carry_out
`endif
);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] psum;
  logic             carry_q;
  logic [CNT_W-1:0] count;
  logic             fa_sum;
  logic             fa_carry;

  full_adder u_fa (
    .a     (a_sh[0]),
    .b     (b_sh[0]),
    .c     (carry_q),
    .sum   (fa_sum),
    .carry (fa_carry)
  );

  // FSM, shift registers, bit counter and result registers; the last RUN
  // step publishes the sum including the bit being added on that edge.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state     <= ST_IDLE;
      a_sh      <= '0;
      b_sh      <= '0;
      psum      <= '0;
      carry_q   <= 1'b0;
      count     <= '0;
      sum_out   <= '0;
      carry_out <= 1'b0;
      done_out  <= 1'b0;
      busy_out  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      overflow_out <= 1'b0;
`endif
    end else begin
      done_out <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_in) begin
            a_sh     <= a_in;
            b_sh     <= b_in;
            carry_q  <= c_in;
            psum     <= '0;
            count    <= '0;
            busy_out <= 1'b1;
            state    <= ST_RUN;
          end
        end
        ST_RUN: begin
          a_sh    <= a_sh >> 1;
          b_sh    <= b_sh >> 1;
          psum    <= {fa_sum, psum[WIDTH-1:1]};
          carry_q <= fa_carry;
          count   <= count + CNT_W'(1);
          if (count == CNT_W'(WIDTH - 1)) begin
            sum_out   <= {fa_sum, psum[WIDTH-1:1]};
            carry_out <= fa_carry;
`ifdef SERIAL_ADDER_OVF_EN
            overflow_out <= carry_q ^ fa_carry;
`endif
            done_out  <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          busy_out <= 1'b0;
          state    <= ST_IDLE;
        end
        default: begin
          busy_out <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Multi-cycle bit-serial adder built around the existing single-bit full adder.
- Accepts two WIDTH-bit operands plus carry-in on a start pulse, then adds one bit per clock, LSB first.
- Holds the full sum and final carry until the next operation.
- Sits around/downstream of the full adder: feeds its a/b/c inputs each cycle and registers its sum/carry outputs.

Parameters:
- WIDTH, 8, operand and sum width in bits (legal range 2..32).
- CNT_W, $clog2(WIDTH+1), bit-count register width (derived; do not override).

Ports:
- clk_in  input  1  single clock; all state updates on rising edge.
- rst_in  input  1  asynchronous, active-high reset.
- start_in  input  1  start request; sampled only in IDLE.
- a_in  input  WIDTH  operand A; captured on accepted start.
- b_in  input  WIDTH  operand B; captured on accepted start.
- c_in  input  1  carry-in; captured on accepted start.
- busy_out  output  1  high while in RUN or DONE.
- done_out  output  1  one-cycle completion pulse.
- sum_out  output  WIDTH  result register; updates only at completion.
- carry_out  output  1  final carry register; updates only at completion.

Behaviour:
- Reset (async assert, any state): state=IDLE; shift regs, carry reg, count, sum_out, carry_out, done_out, busy_out all 0.
- Release of rst_in is synchronous to clk_in.
- IDLE:
  - start_in=1 at an edge: load A/B shift regs from a_in/b_in, carry reg from c_in; count=0; go to RUN.
  - start_in=0: stay in IDLE.
- RUN (each edge):
  - Full adder inputs: A[0], B[0], carry reg.
  - Its sum bit shifts into the MSB of the partial-sum shift reg (shift right).
  - A and B shift right; carry reg takes the full adder carry; count increments.
  - When count reaches WIDTH-1 on this edge (i.e. the last bit is processed): copy the completed partial sum (including the current bit) to sum_out and the new carry to carry_out; go to DONE.
- DONE: done_out=1 for exactly this one cycle; next edge returns to IDLE.
- Latency:
  - Start accepted at edge k; sum_out/carry_out valid after edge k+WIDTH; done_out high in the cycle following edge k+WIDTH.
  - Next start can be accepted at edge k+WIDTH+2.
  - Throughput: one add per WIDTH+2 cycles.
- busy_out: registered; 1 in RUN and DONE, 0 in IDLE.
- start_in while busy: ignored; no queuing, no effect on the operation in progress.
- a_in/b_in/c_in changes after the start edge: no effect.
- sum_out/carry_out:
  - Hold the previous result throughout a new RUN.
  - Never show partial values.
- Arithmetic: {carry_out, sum_out} = a_in + b_in + c_in, unsigned, modulo 2^(WIDTH+1).
- Reset mid-RUN: operation aborted, no done_out, outputs cleared to 0.

Optional Feature:
- Macro: SERIAL_ADDER_OVF_EN.
- Defined:
  - Adds output port overflow_out (1 bit) = signed two's-complement overflow, computed as (carry into MSB) XOR (carry out of MSB).
  - Carry into MSB is the carry reg value at the last RUN step.
  - Updated with sum_out; reset to 0.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Shared package serial_adder_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - default WIDTH constant.
- One sub-module: the existing full_adder, instantiated once for the per-bit add.
- FSM, shift registers, counter and result registers live in serial_adder.

Test Plan:
- WIDTH=8; a=0x5A, b=0x3C, c=0 -> sum_out=0x96, carry_out=0, done_out pulse 9 cycles after the start edge. With SERIAL_ADDER_OVF_EN: overflow_out=1.
- a=0xFF, b=0x01, c=0 -> sum_out=0x00, carry_out=1, overflow_out=0. Then a=0xFF, b=0xFF, c=1 -> sum_out=0xFF, carry_out=1.
- Back-to-back: second start held high through RUN -> ignored until IDLE. Second add accepted at k+10; previous sum_out held stable during the second RUN.
- Operands changed 1 cycle after start (0x12+0x34 captured, then inputs set to 0xFF) -> sum_out=0x46.
- rst_in asserted mid-RUN (cycle 4) -> immediate all-zero outputs, busy_out=0, no done_out. Fresh 0x01+0x01 afterwards -> sum_out=0x02.
- Random regression: 1000 operand/carry triples -> {carry_out, sum_out} matches the reference sum; exactly one done_out per accepted start.
